// File: rtl/gate_direction_decoder_pkg.sv
// gate_direction_decoder_pkg: shared FSM state encoding, sensor patterns and clock rate for the gate lane
package gate_direction_decoder_pkg;

    // Passage FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        IN1        = 3'd1,
        IN2        = 3'd2,
        IN3        = 3'd3,
        OUT1       = 3'd4,
        OUT2       = 3'd5,
        OUT3       = 3'd6,
        WAIT_CLEAR = 3'd7
    } state_t;

    // Sensor pair read as {outer, inner}
    localparam logic [1:0] CLR   = 2'b00;
    localparam logic [1:0] OUTER = 2'b10;
    localparam logic [1:0] BOTH  = 2'b11;
    localparam logic [1:0] INNER = 2'b01;

    // System clock, shared with the sensor debouncers
    localparam int CLK_HZ = 40_000_000;

endpackage

// File: rtl/gate_direction_decoder_timeout_timer.sv
// timeout_timer: clear-on-restart hold counter raising expired once CYCLES cycles have been held
// Ports: clk, reset (async active-low), clear (restart count), expired (count == CYCLES-1)
module timeout_timer #(
    parameter int CYCLES = 80_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expired
);
    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] cnt;

    assign expired = cnt == W'(CYCLES - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else        cnt <= (clear || expired) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/gate_direction_decoder.sv
// gate_direction_decoder: turns debounced outer/inner beam sensors into entry/exit/fault events and tracks occupancy
// Ports: clk, reset (async active-low), sensor_outer/sensor_inner (1 = blocked),
//        entry_pulse/exit_pulse/fault_pulse (one-cycle, registered), occupancy, full, empty
module gate_direction_decoder
    import gate_direction_decoder_pkg::*;
#(
    parameter int CAPACITY       = 16,
    parameter int TIMEOUT_CYCLES = 80_000_000,
    parameter int CNT_W          = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_outer,
    input  logic             sensor_inner,
    output logic             entry_pulse,
    output logic             exit_pulse,
    output logic             fault_pulse,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty
);
    state_t           state, nxt, nxt_state;
    logic [1:0]       s;
    logic             ill, ent, ext, mid, to, bad, ent_ok, ext_ok, flt, clear, expired;
    logic [CNT_W-1:0] occ_nxt;

    always_comb begin
        s   = {sensor_outer, sensor_inner};
        nxt = state;
        ill = 1'b0;
        ent = 1'b0;
        ext = 1'b0;
        unique case (state)
            IDLE: begin
                nxt = s == OUTER ? IN1 : s == INNER ? OUT1 : IDLE;
                ill = s == BOTH;
            end
            IN1: begin
                nxt = s == BOTH ? IN2 : s == CLR ? IDLE : IN1;
                ill = s == INNER;
            end
            IN2: begin
                nxt = s == INNER ? IN3 : s == OUTER ? IN1 : IN2;
                ill = s == CLR;
            end
            IN3: begin
                nxt = s == CLR ? IDLE : s == BOTH ? IN2 : IN3;
                ill = s == OUTER;
                ent = s == CLR;
            end
            OUT1: begin
                nxt = s == BOTH ? OUT2 : s == CLR ? IDLE : OUT1;
                ill = s == OUTER;
            end
            OUT2: begin
                nxt = s == OUTER ? OUT3 : s == INNER ? OUT1 : OUT2;
                ill = s == CLR;
            end
            OUT3: begin
                nxt = s == CLR ? IDLE : s == BOTH ? OUT2 : OUT3;
                ill = s == INNER;
                ext = s == CLR;
            end
            default: nxt = s == CLR ? IDLE : WAIT_CLEAR;
        endcase
        // Only mid-passage states are timed; WAIT_CLEAR waits indefinitely
        mid       = state != IDLE && state != WAIT_CLEAR;
        to        = mid && expired;
        bad       = ill || to;
        nxt_state = bad ? WAIT_CLEAR : nxt;
        ent_ok    = ent && !bad && !full;
        ext_ok    = ext && !bad && !empty;
        // A completed passage that would overflow/underflow is reported as a fault instead
        flt       = bad || (ent && full) || (ext && empty);
        occ_nxt   = ent_ok ? occupancy + 1'b1 : ext_ok ? occupancy - 1'b1 : occupancy;
        clear     = !mid || nxt_state != state;
    end

    timeout_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            fault_pulse <= 1'b0;
            occupancy   <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
        end else begin
            state       <= nxt_state;
            entry_pulse <= ent_ok;
            exit_pulse  <= ext_ok;
            fault_pulse <= flt;
            occupancy   <= occ_nxt;
            full        <= occ_nxt == CNT_W'(CAPACITY);
            empty       <= occ_nxt == '0;
        end
    end
endmodule

// File: tb/tb_gate_direction_decoder.sv
// tb_gate_direction_decoder: directed table-driven bench for the parking gate direction decoder
module tb_gate_direction_decoder;
    localparam int CAP   = 2;
    localparam int TO    = 20;
    localparam int HOLD  = 5;
    localparam int CW    = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          so = 1'b0, si = 1'b0;
    logic          entry_pulse, exit_pulse, fault_pulse, full, empty;
    logic [CW-1:0] occupancy;

    int errors = 0, checks = 0;
    int ec, xc, fc;

    typedef struct {
        string       name;
        logic [11:0] pats;
        int          n, e, x, f, occ;
        logic        emp, ful;
    } vec_t;

    vec_t vt[$];

    gate_direction_decoder #(.CAPACITY(CAP), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .sensor_outer (so),
        .sensor_inner (si),
        .entry_pulse  (entry_pulse),
        .exit_pulse   (exit_pulse),
        .fault_pulse  (fault_pulse),
        .occupancy    (occupancy),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] p);
        @(negedge clk);
        {so, si} = p;
        @(posedge clk);
        #1;
        ec += int'(entry_pulse);
        xc += int'(exit_pulse);
        fc += int'(fault_pulse);
        chk("pulse_onehot", $countones({entry_pulse, exit_pulse, fault_pulse}) <= 1 ? 1 : 0, 1);
    endtask

    task automatic hold(input logic [1:0] p, input int n);
        for (int i = 0; i < n; i++) step(p);
    endtask

    task automatic add(input string nm, input logic [11:0] p, input int n, input int e, input int x,
                       input int f, input int occ, input logic emp, input logic ful);
        vec_t v;
        v.name = nm; v.pats = p; v.n = n; v.e = e; v.x = x; v.f = f;
        v.occ = occ; v.emp = emp; v.ful = ful;
        vt.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        ec = 0; xc = 0; fc = 0;
        for (int i = 0; i < v.n; i++) hold(v.pats[11 - 2 * i -: 2], HOLD);
        chk({v.name, "_entry"}, ec, v.e);
        chk({v.name, "_exit"}, xc, v.x);
        chk({v.name, "_fault"}, fc, v.f);
        chk({v.name, "_occ"}, int'(occupancy), v.occ);
        chk({v.name, "_empty"}, int'(empty), int'(v.emp));
        chk({v.name, "_full"}, int'(full), int'(v.ful));
    endtask

    localparam logic [11:0] P_ENTRY = {2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00};
    localparam logic [11:0] P_EXIT  = {2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00};

    initial begin
        int fault_at;
        add("entry",    P_ENTRY, 5, 1, 0, 0, 1, 1'b0, 1'b0);
        add("exit",     P_EXIT,  5, 0, 1, 0, 0, 1'b1, 1'b0);
        add("underflow",P_EXIT,  5, 0, 0, 1, 0, 1'b1, 1'b0);
        add("backout",  {2'b10, 2'b00, 8'h00}, 2, 0, 0, 0, 0, 1'b1, 1'b0);
        add("reversal", {2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00}, 6, 1, 0, 0, 1, 1'b0, 1'b0);
        add("exit2",    P_EXIT,  5, 0, 1, 0, 0, 1'b1, 1'b0);
        add("ovf1",     P_ENTRY, 5, 1, 0, 0, 1, 1'b0, 1'b0);
        add("ovf2",     P_ENTRY, 5, 1, 0, 0, 2, 1'b0, 1'b1);
        add("ovf3",     P_ENTRY, 5, 0, 0, 1, 2, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_occ", int'(occupancy), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_pulses", int'({entry_pulse, exit_pulse, fault_pulse}), 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vt[i]) run_vec(vt[i]);

        // Timeout: IN1 entered on the first edge sampling 10, fault visible TO edges later
        ec = 0; xc = 0; fc = 0; fault_at = -1;
        for (int k = 1; k <= 25; k++) begin
            step(2'b10);
            if (fault_pulse && fault_at < 0) fault_at = k;
        end
        chk("timeout_edge", fault_at, TO + 1);
        chk("timeout_faults", fc, 1);
        ec = 0; xc = 0; fc = 0;
        hold(2'b11, HOLD);
        hold(2'b01, HOLD);
        hold(2'b00, HOLD);
        chk("waitclear_events", ec + xc + fc, 0);
        chk("waitclear_occ", int'(occupancy), 2);

        // Illegal IDLE 00 -> 11 faults on the very first edge
        ec = 0; xc = 0; fc = 0;
        step(2'b11);
        chk("illegal_immediate", int'(fault_pulse), 1);
        hold(2'b11, HOLD - 1);
        hold(2'b00, HOLD);
        chk("illegal_faults", fc, 1);
        chk("illegal_occ", int'(occupancy), 2);

        // Asynchronous reset in the middle of a passage
        ec = 0; xc = 0; fc = 0;
        hold(2'b10, HOLD);
        hold(2'b11, HOLD);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("amid_occ", int'(occupancy), 0);
        chk("amid_empty", int'(empty), 1);
        chk("amid_full", int'(full), 0);
        chk("amid_pulses", int'({entry_pulse, exit_pulse, fault_pulse}), 0);
        chk("amid_events", ec + xc + fc, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        so = 1'b0; si = 1'b0;
        run_vec(vt[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
